abm_block_sequencer: RTL

- Parametrised successor to the fixed 1 MB single-shot sender.
- Issues a programmable sequence of block copies to a data_mover instance through its command interface (src_address, dst_address, byte_count, burst_size, start, idle).
- Per-block source/destination strides give scatter/gather-style multi-block transfers.
- Adds configuration checking, graceful abort and a block-progress counter.

---
 rtl/abm_block_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/abm_block_sequencer.sv
// Block-copy sequencer: walks a strided list of blocks and issues one data_mover command per block.
// Optional macro ABM_SEQ_PERF_EN adds a saturating busy-cycle counter on output perf_cycles.
module abm_block_sequencer #(
  parameter int AW         = 64,
  parameter int CW         = 16,
  parameter int MAX_BURST  = 4096,
  parameter int BEAT_BYTES = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] cfg_src_base,
  input  logic [AW-1:0] cfg_dst_base,
  input  logic [AW-1:0] cfg_src_stride,
  input  logic [AW-1:0] cfg_dst_stride,
  input  logic [31:0]   cfg_block_bytes,
  input  logic [CW-1:0] cfg_block_count,
  input  logic [15:0]   cfg_burst_size,
  output logic          idle,
  output logic          done,
  output logic          cfg_error,
  output logic          aborted,
  output logic [CW-1:0] blocks_done,
  output logic [AW-1:0] dm_src_address,
  output logic [AW-1:0] dm_dst_address,
  output logic [63:0]   dm_byte_count,
  output logic [15:0]   dm_burst_size,
  output logic          dm_start,
  input  logic          dm_idle
`ifdef ABM_SEQ_PERF_EN
  , output logic [31:0] perf_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT_DM,
    LAUNCH,
    WAIT_BUSY,
    WAIT_IDLE,
    FINISH
  } state_t;

  localparam logic [AW-1:0] ADDR_MASK  = AW'(BEAT_BYTES - 1);
  localparam logic [31:0]   BYTES_MASK = 32'(BEAT_BYTES - 1);
  localparam logic [15:0]   BURST_MASK = 16'(BEAT_BYTES - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_src_next;
  logic [AW-1:0] r_dst_next;
  logic [AW-1:0] r_src_stride;
  logic [AW-1:0] r_dst_stride;
  logic [31:0]   r_block_bytes;
  logic [CW-1:0] r_block_count;
  logic [15:0]   r_burst_size;
  logic          r_idle;
  logic          r_cfg_error;
  logic          r_aborted;
  logic [CW-1:0] r_blocks_done;
  logic [AW-1:0] r_dm_src;
  logic [AW-1:0] r_dm_dst;
  logic [63:0]   r_dm_bytes;
  logic [15:0]   r_dm_burst;

  logic w_accept;
  logic w_cfg_bad;
  logic w_last;
  logic w_load_launch;
  logic w_block_end;
  logic w_done;
  logic w_dm_start;

  // r_src_next/r_dst_next still hold the bases while in CHECK, so alignment is checked on them.
  assign w_cfg_bad = (r_block_count == '0) ||
                     (r_block_bytes == '0) ||
                     (r_burst_size == '0) ||
                     (32'(r_burst_size) > 32'(MAX_BURST)) ||
                     ((r_burst_size & BURST_MASK) != '0) ||
                     ((r_block_bytes & BYTES_MASK) != '0) ||
                     ((r_src_next & ADDR_MASK) != '0) ||
                     ((r_dst_next & ADDR_MASK) != '0);

  assign w_last = (r_blocks_done + CW'(1)) == r_block_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_load_launch = 1'b0;
    w_block_end   = 1'b0;
    w_done        = 1'b0;
    w_dm_start    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = CHECK;
        end
      end
      CHECK:     w_state_next = w_cfg_bad ? FINISH : WAIT_DM;
      WAIT_DM: begin
        if (dm_idle) begin
          w_load_launch = 1'b1;
          w_state_next  = LAUNCH;
        end
      end
      LAUNCH: begin
        w_dm_start   = 1'b1;
        w_state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!dm_idle) w_state_next = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (dm_idle) begin
          w_block_end  = 1'b1;
          w_state_next = (w_last || abort) ? FINISH : WAIT_DM;
        end
      end
      FINISH: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default:   w_state_next = IDLE;
    endcase
  end

  // Command registers load on entry to LAUNCH so they hold steady across the whole block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src_next    <= '0;
      r_dst_next    <= '0;
      r_src_stride  <= '0;
      r_dst_stride  <= '0;
      r_block_bytes <= '0;
      r_block_count <= '0;
      r_burst_size  <= '0;
      r_idle        <= 1'b1;
      r_cfg_error   <= 1'b0;
      r_aborted     <= 1'b0;
      r_blocks_done <= '0;
      r_dm_src      <= '0;
      r_dm_dst      <= '0;
      r_dm_bytes    <= '0;
      r_dm_burst    <= '0;
    end else begin
      if (w_accept) begin
        r_src_next    <= cfg_src_base;
        r_dst_next    <= cfg_dst_base;
        r_src_stride  <= cfg_src_stride;
        r_dst_stride  <= cfg_dst_stride;
        r_block_bytes <= cfg_block_bytes;
        r_block_count <= cfg_block_count;
        r_burst_size  <= cfg_burst_size;
        r_idle        <= 1'b0;
        r_cfg_error   <= 1'b0;
        r_aborted     <= 1'b0;
        r_blocks_done <= '0;
      end
      if (r_state == CHECK && w_cfg_bad) r_cfg_error <= 1'b1;
      if (w_load_launch) begin
        r_dm_src   <= r_src_next;
        r_dm_dst   <= r_dst_next;
        r_dm_bytes <= 64'(r_block_bytes);
        r_dm_burst <= r_burst_size;
      end
      if (w_block_end) begin
        r_blocks_done <= r_blocks_done + CW'(1);
        r_src_next    <= r_src_next + r_src_stride;
        r_dst_next    <= r_dst_next + r_dst_stride;
        if (abort && !w_last) r_aborted <= 1'b1;
      end
      if (r_state == FINISH) r_idle <= 1'b1;
    end
  end

`ifdef ABM_SEQ_PERF_EN
  logic [31:0] r_perf_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  r_perf_cycles <= '0;
    else if (w_accept)                          r_perf_cycles <= '0;
    else if (!r_idle && (r_perf_cycles != '1))  r_perf_cycles <= r_perf_cycles + 32'd1;
  end

  assign perf_cycles = r_perf_cycles;
`endif

  assign idle           = r_idle;
  assign done           = w_done;
  assign cfg_error      = r_cfg_error;
  assign aborted        = r_aborted;
  assign blocks_done    = r_blocks_done;
  assign dm_src_address = r_dm_src;
  assign dm_dst_address = r_dm_dst;
  assign dm_byte_count  = r_dm_bytes;
  assign dm_burst_size  = r_dm_burst;
  assign dm_start       = w_dm_start;

endmodule
